hazard_stall_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage RV32I core. It produces the PC/IF-ID write enables, the IF/ID flush, the ID/EX bubble and the whole-pipe hold. It arbitrates between these sources:
- load-use and branch-in-ID data hazards that forwarding cannot cover;
- EX branch redirects;
- data-memory wait states, with a timeout;
- a halt/drain/resume debug request.

It sits beside the forwarding unit and the pipeline registers; it never touches operand muxes.

---
 rtl/hazard_stall_ctrl_pkg.sv | 25 ++
 rtl/hazard_stall_ctrl_if.sv | 46 ++++
 rtl/hazard_stall_ctrl_id_hazard_detect.sv | 34 +++
 rtl/hazard_stall_ctrl.sv | 175 +++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: RV32I opcodes,
// controller states and the rs2-usage decode.
package hazard_stall_ctrl_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } ctrl_state_e;

  // Formats without an rs2 field must not create false hazards on rs2 bits.
  function automatic logic uses_rs2(input logic [6:0] opcode);
    return !(opcode inside {OP_IMM, OP_LOAD, OP_JAL, OP_LUI, OP_AUIPC, OP_JALR});
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the
// sequencing controller (slave).
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [6:0]       id_opcode;
  logic             idex_memread;
  logic             idex_regwrite;
  logic [4:0]       idex_rd;
  logic             exmem_memread;
  logic             exmem_memwrite;
  logic [4:0]       exmem_rd;
  logic             dmem_ready;
  logic             branch_taken;
  logic             halt_req;
  logic             resume;

  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             pipe_hold;
  logic             halted;
  logic             bus_error;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs1, id_rs2, id_opcode, idex_memread, idex_regwrite, idex_rd,
           exmem_memread, exmem_memwrite, exmem_rd, dmem_ready, branch_taken,
           halt_req, resume,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold,
           halted, bus_error, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_opcode, idex_memread, idex_regwrite, idex_rd,
           exmem_memread, exmem_memwrite, exmem_rd, dmem_ready, branch_taken,
           halt_req, resume,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold,
           halted, bus_error, stall_cycles, flush_count
  );

endinterface

// File: rtl/hazard_stall_ctrl_id_hazard_detect.sv
// Combinational ID-stage hazard detection: load-use and branch operands
// that forwarding cannot deliver in time.
module id_hazard_detect
  import hazard_stall_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic [6:0] id_opcode_i,
  input  logic       idex_memread_i,
  input  logic       idex_regwrite_i,
  input  logic [4:0] idex_rd_i,
  input  logic       exmem_memread_i,
  input  logic [4:0] exmem_rd_i,
  output logic       load_use_o,
  output logic       br_haz_o
);

  logic rs2_used;
  logic idex_match;
  logic exmem_match;

  assign rs2_used = uses_rs2(id_opcode_i);

  // x0 is hardwired to zero, so a write to it never produces a dependency.
  assign idex_match  = (idex_rd_i != 5'd0) &
                       ((id_rs1_i == idex_rd_i) | (rs2_used & (id_rs2_i == idex_rd_i)));
  assign exmem_match = (exmem_rd_i != 5'd0) &
                       ((id_rs1_i == exmem_rd_i) | (rs2_used & (id_rs2_i == exmem_rd_i)));

  assign load_use_o = idex_memread_i & idex_match;
  assign br_haz_o   = (id_opcode_i == OP_BRANCH) &
                      ((idex_regwrite_i & idex_match) | (exmem_memread_i & exmem_match));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: arbitrates hazards, redirects, data-memory
// wait states and debug halt into PC/IF/ID enables, flush, bubble and hold.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input logic                clk,
  input logic                rst_n,
  hazard_stall_ctrl_if.slave bus
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  ctrl_state_e      state_q, state_d;
  ctrl_state_e      ret_q, ret_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [1:0]       drain_cnt_q, drain_cnt_d;
  logic             halted_q;
  logic             bus_error_q, bus_error_d;
  logic [CNT_W-1:0] stall_cycles_q;
  logic [CNT_W-1:0] flush_count_q;

  logic load_use, br_haz, hazard;
  logic mem_pending, frozen, drain_mode, halt_accept;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold;

  id_hazard_detect u_hazard (
    .id_rs1_i        (bus.id_rs1),
    .id_rs2_i        (bus.id_rs2),
    .id_opcode_i     (bus.id_opcode),
    .idex_memread_i  (bus.idex_memread),
    .idex_regwrite_i (bus.idex_regwrite),
    .idex_rd_i       (bus.idex_rd),
    .exmem_memread_i (bus.exmem_memread),
    .exmem_rd_i      (bus.exmem_rd),
    .load_use_o      (load_use),
    .br_haz_o        (br_haz)
  );

  assign hazard      = load_use | br_haz;
  assign mem_pending = (bus.exmem_memread | bus.exmem_memwrite) & ~bus.dmem_ready;
  // Once waiting, only dmem_ready matters: the access itself is frozen in EX/MEM.
  assign frozen      = (state_q == ST_MEM_WAIT) ? ~bus.dmem_ready : mem_pending;
  assign drain_mode  = (state_q == ST_DRAIN) |
                       ((state_q == ST_MEM_WAIT) & (ret_q == ST_DRAIN));
  assign halt_accept = (state_q == ST_RUN) & bus.halt_req &
                       ~mem_pending & ~bus.branch_taken & ~hazard;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      ret_q       <= ST_RUN;
      wait_cnt_q  <= 8'd0;
      drain_cnt_q <= 2'd0;
      halted_q    <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      wait_cnt_q  <= wait_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      halted_q    <= (state_d == ST_HALTED);
      bus_error_q <= bus_error_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    wait_cnt_d  = wait_cnt_q;
    drain_cnt_d = drain_cnt_q;
    bus_error_d = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (mem_pending) begin
          state_d    = ST_MEM_WAIT;
          ret_d      = ST_RUN;
          wait_cnt_d = 8'd1;
        end else if (halt_accept) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = 2'd3;
        end
      end
      ST_DRAIN: begin
        if (mem_pending) begin
          state_d    = ST_MEM_WAIT;
          ret_d      = ST_DRAIN;
          wait_cnt_d = 8'd1;
        end else begin
          drain_cnt_d = drain_cnt_q - 2'd1;
          if (drain_cnt_q == 2'd1) state_d = ST_HALTED;
        end
      end
      ST_MEM_WAIT: begin
        if (bus.dmem_ready) begin
          state_d    = ret_q;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == TIMEOUT_CNT) begin
          state_d     = ST_HALTED;
          wait_cnt_d  = 8'd0;
          bus_error_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_HALTED: begin
        if (bus.resume) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_hold    = 1'b0;
    if (state_q == ST_HALTED) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else begin
      if (frozen) begin
        pipe_hold   = 1'b1;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
      end else if (bus.branch_taken) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (hazard) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end else if (halt_accept) begin
        if_id_flush = 1'b1;
        pc_write    = 1'b0;
      end
      // A freeze holds ID/EX as-is, so the drain bubble only applies unfrozen.
      if (drain_mode && !frozen) begin
        pc_write     = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (!pc_write && (state_q != ST_HALTED) && (stall_cycles_q != '1))
        stall_cycles_q <= stall_cycles_q + 1'b1;
      if (if_id_flush && (flush_count_q != '1))
        flush_count_q <= flush_count_q + 1'b1;
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.if_id_write  = if_id_write;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_bubble = id_ex_bubble;
  assign bus.pipe_hold    = pipe_hold;
  assign bus.halted       = halted_q;
  assign bus.bus_error    = bus_error_q;
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus a randomized run
// against a flag-based reference model of the sequencing rules.
module tb_hazard_stall_ctrl;

  localparam int TB_TIMEOUT = 8;
  localparam int TB_CNT_W   = 6;
  localparam int CNT_MAX    = (1 << TB_CNT_W) - 1;

  // Output vector order: {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold}
  localparam logic [4:0] O_IDLE   = 5'b11000;
  localparam logic [4:0] O_STALL  = 5'b00010;
  localparam logic [4:0] O_BRANCH = 5'b11110;
  localparam logic [4:0] O_FREEZE = 5'b00001;
  localparam logic [4:0] O_ACCEPT = 5'b01100;
  localparam logic [4:0] O_DRAIN  = 5'b01010;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  hazard_stall_ctrl_if #(.CNT_W(TB_CNT_W)) bus ();

  hazard_stall_ctrl #(.MEM_TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] outs();
    return {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble, bus.pipe_hold};
  endfunction

  task automatic set_idle();
    bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0; bus.id_opcode = 7'b0110011;
    bus.idex_memread = 1'b0; bus.idex_regwrite = 1'b0; bus.idex_rd = 5'd0;
    bus.exmem_memread = 1'b0; bus.exmem_memwrite = 1'b0; bus.exmem_rd = 5'd0;
    bus.dmem_ready = 1'b1; bus.branch_taken = 1'b0;
    bus.halt_req = 1'b0; bus.resume = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic set_load_use();
    bus.idex_memread = 1'b1; bus.idex_rd = 5'd5; bus.id_rs1 = 5'd5;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (outs() !== O_IDLE) begin errors++; $display("FAIL reset_outs got %b exp %b", outs(), O_IDLE); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", bus.halted); end
    checks++; if (bus.bus_error !== 1'b0) begin errors++; $display("FAIL reset_bus_error got %b exp 0", bus.bus_error); end
    checks++; if (bus.stall_cycles !== '0) begin errors++; $display("FAIL reset_stall got %0d exp 0", bus.stall_cycles); end
    checks++; if (bus.flush_count !== '0) begin errors++; $display("FAIL reset_flush got %0d exp 0", bus.flush_count); end
    next_cycle();
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use();
    @(negedge clk);
    checks++; if (outs() !== O_STALL) begin errors++; $display("FAIL load_use_outs got %b exp %b", outs(), O_STALL); end
    next_cycle();
    set_idle();
    @(negedge clk);
    checks++; if (bus.stall_cycles !== 6'd1) begin errors++; $display("FAIL load_use_stall_cnt got %0d exp 1", bus.stall_cycles); end
    checks++; if (outs() !== O_IDLE) begin errors++; $display("FAIL load_use_release got %b exp %b", outs(), O_IDLE); end
    next_cycle();
    bus.idex_memread = 1'b1; bus.idex_rd = 5'd0; bus.id_rs1 = 5'd0;
    @(negedge clk);
    checks++; if (outs() !== O_IDLE) begin errors++; $display("FAIL load_use_rd0 got %b exp %b", outs(), O_IDLE); end
    next_cycle();
    set_idle();
    @(negedge clk);
    checks++; if (bus.stall_cycles !== 6'd1) begin errors++; $display("FAIL load_use_rd0_cnt got %0d exp 1", bus.stall_cycles); end
    next_cycle();
  endtask

  task automatic test_branch_on_load();
    int   nstall = 0;
    logic last_pc = 1'b0;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_idle();
      bus.id_opcode = 7'b1100011; bus.id_rs1 = 5'd1; bus.id_rs2 = 5'd7;
      if (c == 0) begin
        bus.idex_memread = 1'b1; bus.idex_regwrite = 1'b1; bus.idex_rd = 5'd7;
      end else if (c == 1) begin
        bus.exmem_memread = 1'b1; bus.exmem_rd = 5'd7;
      end
      @(negedge clk);
      if (!bus.pc_write) nstall++;
      last_pc = bus.pc_write;
      next_cycle();
    end
    set_idle();
    @(negedge clk);
    checks++; if (nstall != 2) begin errors++; $display("FAIL br_load_stalls got %0d exp 2", nstall); end
    checks++; if (last_pc !== 1'b1) begin errors++; $display("FAIL br_load_resume got %b exp 1", last_pc); end
    checks++; if (bus.stall_cycles !== 6'd2) begin errors++; $display("FAIL br_load_cnt got %0d exp 2", bus.stall_cycles); end
    next_cycle();
  endtask

  task automatic test_branch_flush();
    do_reset();
    set_load_use();
    bus.branch_taken = 1'b1;
    @(negedge clk);
    checks++; if (outs() !== O_BRANCH) begin errors++; $display("FAIL br_flush_outs got %b exp %b", outs(), O_BRANCH); end
    next_cycle();
    set_idle();
    @(negedge clk);
    checks++; if (bus.flush_count !== 6'd1) begin errors++; $display("FAIL br_flush_cnt got %0d exp 1", bus.flush_count); end
    checks++; if (bus.stall_cycles !== 6'd0) begin errors++; $display("FAIL br_flush_stall got %0d exp 0", bus.stall_cycles); end
    next_cycle();
  endtask

  task automatic test_mem_wait();
    do_reset();
    bus.exmem_memread = 1'b1; bus.exmem_rd = 5'd3; bus.branch_taken = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.dmem_ready = (c == 4);
      @(negedge clk);
      checks++;
      if (c < 4) begin
        if (outs() !== O_FREEZE) begin errors++; $display("FAIL mem_wait_freeze[%0d] got %b exp %b", c, outs(), O_FREEZE); end
      end else begin
        if (outs() !== O_BRANCH) begin errors++; $display("FAIL mem_wait_release got %b exp %b", outs(), O_BRANCH); end
      end
      next_cycle();
    end
    set_idle();
    @(negedge clk);
    checks++; if (bus.flush_count !== 6'd1) begin errors++; $display("FAIL mem_wait_flush_cnt got %0d exp 1", bus.flush_count); end
    checks++; if (bus.stall_cycles !== 6'd4) begin errors++; $display("FAIL mem_wait_stall_cnt got %0d exp 4", bus.stall_cycles); end
    next_cycle();
  endtask

  task automatic test_timeout();
    int found = -1;
    do_reset();
    bus.exmem_memread = 1'b1; bus.dmem_ready = 1'b0;
    for (int i = 0; i < 40 && found < 0; i++) begin
      @(negedge clk);
      if (bus.bus_error === 1'b1) found = i;
      else next_cycle();
    end
    // One RUN cycle plus TB_TIMEOUT wait cycles, then the registered pulse.
    checks++; if (found != TB_TIMEOUT + 1) begin errors++; $display("FAIL timeout_latency got %0d exp %0d", found, TB_TIMEOUT + 1); end
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL timeout_halted got %b exp 1", bus.halted); end
    checks++; if (outs() !== O_STALL) begin errors++; $display("FAIL timeout_halt_outs got %b exp %b", outs(), O_STALL); end
    next_cycle();
    set_idle();
    @(negedge clk);
    checks++; if (bus.bus_error !== 1'b0) begin errors++; $display("FAIL timeout_pulse_width got %b exp 0", bus.bus_error); end
    next_cycle();
    bus.resume = 1'b1;
    @(negedge clk);
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL timeout_resume_cycle got %b exp 1", bus.halted); end
    next_cycle();
    bus.resume = 1'b0;
    @(negedge clk);
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL timeout_resumed got %b exp 0", bus.halted); end
    checks++; if (outs() !== O_IDLE) begin errors++; $display("FAIL timeout_run_outs got %b exp %b", outs(), O_IDLE); end
    checks++; if (bus.stall_cycles !== 6'(TB_TIMEOUT + 1)) begin errors++; $display("FAIL timeout_stall_cnt got %0d exp %0d", bus.stall_cycles, TB_TIMEOUT + 1); end
    next_cycle();
  endtask

  task automatic test_halt();
    int n = 0;
    bit seen = 1'b0;
    do_reset();
    bus.halt_req = 1'b1;
    set_load_use();
    @(negedge clk);
    checks++; if (outs() !== O_STALL) begin errors++; $display("FAIL halt_deferred got %b exp %b", outs(), O_STALL); end
    next_cycle();
    bus.idex_memread = 1'b0;
    @(negedge clk);
    checks++; if (outs() !== O_ACCEPT) begin errors++; $display("FAIL halt_accept got %b exp %b", outs(), O_ACCEPT); end
    for (int i = 0; i < 10 && !seen; i++) begin
      next_cycle();
      @(negedge clk);
      if (bus.halted === 1'b1) seen = 1'b1;
      else begin
        n++;
        checks++; if (outs() !== O_DRAIN) begin errors++; $display("FAIL halt_drain_outs[%0d] got %b exp %b", i, outs(), O_DRAIN); end
      end
    end
    checks++; if (n != 3 || !seen) begin errors++; $display("FAIL halt_latency got %0d drain cycles (seen=%0d) exp 3", n, seen); end
    checks++; if (bus.stall_cycles !== 6'd5) begin errors++; $display("FAIL halt_stall_cnt got %0d exp 5", bus.stall_cycles); end
    checks++; if (bus.flush_count !== 6'd1) begin errors++; $display("FAIL halt_flush_cnt got %0d exp 1", bus.flush_count); end
    next_cycle();
    bus.halt_req = 1'b0;
    @(negedge clk);
    checks++; if (outs() !== O_STALL) begin errors++; $display("FAIL halted_outs got %b exp %b", outs(), O_STALL); end
    next_cycle();
    bus.resume = 1'b1;
    next_cycle();
    bus.resume = 1'b0;
    @(negedge clk);
    checks++; if (bus.halted !== 1'b0 || outs() !== O_IDLE) begin errors++; $display("FAIL halt_resume got halted=%b outs=%b exp 0 %b", bus.halted, outs(), O_IDLE); end
    next_cycle();
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    bus.halt_req = 1'b1;
    next_cycle();
    bus.halt_req = 1'b0;
    @(negedge clk);
    checks++; if (outs() !== O_DRAIN) begin errors++; $display("FAIL rst_drain_entered got %b exp %b", outs(), O_DRAIN); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (outs() !== O_IDLE || bus.halted !== 1'b0 || bus.bus_error !== 1'b0) begin
      errors++; $display("FAIL rst_drain_abort got outs=%b halted=%b berr=%b exp %b 0 0", outs(), bus.halted, bus.bus_error, O_IDLE);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) next_cycle();
    @(negedge clk);
    checks++; if (bus.halted !== 1'b0 || outs() !== O_IDLE) begin errors++; $display("FAIL rst_drain_run got halted=%b outs=%b exp 0 %b", bus.halted, outs(), O_IDLE); end
    next_cycle();
  endtask

  task automatic test_saturation();
    do_reset();
    set_load_use();
    repeat (CNT_MAX + 7) next_cycle();
    set_idle();
    bus.branch_taken = 1'b1;
    repeat (CNT_MAX + 7) next_cycle();
    set_idle();
    @(negedge clk);
    checks++; if (bus.stall_cycles !== 6'(CNT_MAX)) begin errors++; $display("FAIL sat_stall got %0d exp %0d", bus.stall_cycles, CNT_MAX); end
    checks++; if (bus.flush_count !== 6'(CNT_MAX)) begin errors++; $display("FAIL sat_flush got %0d exp %0d", bus.flush_count, CNT_MAX); end
    next_cycle();
  endtask

  // Reference model: plain flags describing what the pipeline is doing.
  bit m_halted, m_waiting, m_draining, m_bus_err;
  int m_waits, m_drain_left, m_stall, m_flush;

  function automatic bit ref_reads(input logic [4:0] r);
    bit two = !(bus.id_opcode inside {7'b0010011, 7'b0000011, 7'b1101111,
                                      7'b0110111, 7'b0010111, 7'b1100111});
    return (r != 5'd0) && ((bus.id_rs1 == r) || (two && (bus.id_rs2 == r)));
  endfunction

  function automatic bit ref_hazard();
    bit lu = bus.idex_memread && ref_reads(bus.idex_rd);
    bit bh = (bus.id_opcode == 7'b1100011) &&
             ((bus.idex_regwrite && ref_reads(bus.idex_rd)) ||
              (bus.exmem_memread && ref_reads(bus.exmem_rd)));
    return lu || bh;
  endfunction

  function automatic bit ref_pending();
    return (bus.exmem_memread || bus.exmem_memwrite) && !bus.dmem_ready;
  endfunction

  function automatic logic [4:0] ref_outs();
    logic [4:0] o;
    bit freeze = m_waiting ? !bus.dmem_ready : ref_pending();
    if (m_halted) return O_STALL;
    if (freeze)                                         o = O_FREEZE;
    else if (bus.branch_taken)                          o = O_BRANCH;
    else if (ref_hazard())                              o = O_STALL;
    else if (!m_draining && !m_waiting && bus.halt_req) o = O_ACCEPT;
    else                                                o = O_IDLE;
    if (m_draining && !freeze) begin o[4] = 1'b0; o[1] = 1'b1; end
    return o;
  endfunction

  task automatic ref_step(input logic [4:0] e);
    bit pend = ref_pending();
    bit acc  = (e == O_ACCEPT) && !m_halted && !m_waiting && !m_draining;
    if (!e[4] && !m_halted && m_stall < CNT_MAX) m_stall++;
    if (e[2] && m_flush < CNT_MAX) m_flush++;
    m_bus_err = 1'b0;
    if (m_halted) begin
      if (bus.resume) m_halted = 1'b0;
    end else if (m_waiting) begin
      if (bus.dmem_ready) m_waiting = 1'b0;
      else if (m_waits == TB_TIMEOUT) begin
        m_bus_err = 1'b1; m_halted = 1'b1; m_waiting = 1'b0; m_draining = 1'b0;
      end else m_waits++;
    end else if (pend) begin
      m_waiting = 1'b1; m_waits = 1;
    end else if (m_draining) begin
      m_drain_left--;
      if (m_drain_left == 0) begin m_draining = 1'b0; m_halted = 1'b1; end
    end else if (acc) begin
      m_draining = 1'b1; m_drain_left = 3;
    end
  endtask

  task automatic test_random();
    logic [6:0] opc_tab [9] = '{7'b1100011, 7'b0000011, 7'b0010011, 7'b0110011,
                                7'b0100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    bit halt_hold = 1'b0;
    bit slow = 1'b0;
    logic [4:0] e;
    int k;
    do_reset();
    m_halted = 0; m_waiting = 0; m_draining = 0; m_bus_err = 0;
    m_waits = 0; m_drain_left = 0; m_stall = 0; m_flush = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      k = $urandom_range(0, 8);
      bus.id_opcode      = opc_tab[k];
      bus.id_rs1         = 5'($urandom_range(0, 3));
      bus.id_rs2         = 5'($urandom_range(0, 3));
      bus.idex_memread   = ($urandom_range(0, 3) == 0);
      bus.idex_regwrite  = ($urandom_range(0, 1) == 0);
      bus.idex_rd        = 5'($urandom_range(0, 3));
      bus.exmem_memread  = ($urandom_range(0, 4) == 0);
      bus.exmem_memwrite = ($urandom_range(0, 6) == 0);
      bus.exmem_rd       = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) slow = !slow;
      bus.dmem_ready     = ($urandom_range(0, 9) < (slow ? 1 : 6));
      bus.branch_taken   = ($urandom_range(0, 7) == 0);
      if (m_halted) halt_hold = 1'b0;
      else if (!halt_hold && $urandom_range(0, 39) == 0) halt_hold = 1'b1;
      bus.halt_req       = halt_hold;
      bus.resume         = m_halted && ($urandom_range(0, 4) == 0);
      @(negedge clk);
      e = ref_outs();
      checks++; if (outs() !== e) begin errors++; $display("FAIL rnd_outs cyc %0d got %b exp %b", cyc, outs(), e); end
      checks++; if (bus.halted !== m_halted) begin errors++; $display("FAIL rnd_halted cyc %0d got %b exp %b", cyc, bus.halted, m_halted); end
      checks++; if (bus.bus_error !== m_bus_err) begin errors++; $display("FAIL rnd_bus_error cyc %0d got %b exp %b", cyc, bus.bus_error, m_bus_err); end
      checks++; if (bus.stall_cycles !== 6'(m_stall)) begin errors++; $display("FAIL rnd_stall cyc %0d got %0d exp %0d", cyc, bus.stall_cycles, m_stall); end
      checks++; if (bus.flush_count !== 6'(m_flush)) begin errors++; $display("FAIL rnd_flush cyc %0d got %0d exp %0d", cyc, bus.flush_count, m_flush); end
      ref_step(e);
      next_cycle();
    end
    set_idle();
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    test_reset();
    test_load_use();
    test_branch_on_load();
    test_branch_flush();
    test_mem_wait();
    test_timeout();
    test_halt();
    test_reset_in_drain();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
